al_accel_linebuf: RTL and testbench

Streaming 3-row line buffer directly upstream of the LPU input register stage. Accepts one 8-bit pixel per handshake in raster order and stores the two previous image rows. For each pixel it emits a vertically aligned 3-pixel column (rows y-2, y-1, y) together with a one-cycle load strobe that the downstream LPU register consumes as its load-enable.

---
 rtl/al_accel_linebuf.sv | 179 +++++++++++++++++
 tb/tb_al_accel_linebuf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/al_accel_linebuf.sv
// al_accel_linebuf: streaming 3-row line buffer feeding the LPU input register.
// Stores the two previous image rows and, for every pixel in rows 2 and later,
// emits the vertically aligned column (y-2, y-1, y) with a one-cycle load strobe.
// Optional macro AL_ACCEL_LB_PAD_EN: zero-padded top border, streaming from row 0.
module al_accel_linebuf #(
    parameter int IMG_W    = 28,
    parameter int COL_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enb,
    input  logic                start,
    input  logic [COL_BITS-1:0] cfg_width,
    input  logic [COL_BITS-1:0] cfg_height,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic [7:0]          lb_do_0,
    output logic [7:0]          lb_do_1,
    output logic [7:0]          lb_do_2,
    output logic                lb_ld_wrn,
    output logic [COL_BITS-1:0] lb_col,
    output logic                busy,
    output logic                frame_done,
    output logic                cfg_err
);

    localparam int ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [COL_BITS-1:0] MAX_W = COL_BITS'(IMG_W);
    localparam logic [COL_BITS-1:0] ONE   = COL_BITS'(1);
`ifdef AL_ACCEL_LB_PAD_EN
    localparam logic [COL_BITS-1:0] MIN_H = COL_BITS'(1);
`else
    localparam logic [COL_BITS-1:0] MIN_H = COL_BITS'(3);
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              state;
    logic [COL_BITS-1:0] col;
    logic [COL_BITS-1:0] row;
    logic [COL_BITS-1:0] width_q;
    logic [COL_BITS-1:0] height_q;

    logic [7:0]          mem0 [IMG_W];
    logic [7:0]          mem1 [IMG_W];

    logic [7:0]          do0_q;
    logic [7:0]          do1_q;
    logic [7:0]          do2_q;
    logic [COL_BITS-1:0] col_q;
    logic                ld_q;
    logic                done_q;
    logic                err_q;

    logic [ADDR_W-1:0]   addr;
    logic [7:0]          rd0;
    logic [7:0]          rd1;
    logic [7:0]          tap0;
    logic [7:0]          tap1;
    logic                accept;
    logic                last_col;
    logic                last_row;
    logic                cfg_ok;

    assign in_ready = enb && ((state == S_FILL) || (state == S_STREAM));
    assign accept   = in_valid && in_ready;
    assign addr     = col[ADDR_W-1:0];
    assign rd0      = mem0[addr];
    assign rd1      = mem1[addr];
    assign last_col = (col == width_q - ONE);
    assign last_row = (row == height_q - ONE);
    assign cfg_ok   = (cfg_width != '0) && (cfg_width <= MAX_W) && (cfg_height >= MIN_H);

    // Column taps: with padding, rows above the image read as zero
    always_comb begin
        tap0 = rd0;
        tap1 = rd1;
`ifdef AL_ACCEL_LB_PAD_EN
        if (row < COL_BITS'(2)) tap0 = '0;
        if (row == '0)          tap1 = '0;
`endif
    end

    // Line memories: shift the column up one row on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            mem0[addr] <= rd1;
            mem1[addr] <= in_data;
        end
    end

    // Frame FSM, row/column counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            col      <= '0;
            row      <= '0;
            width_q  <= '0;
            height_q <= '0;
            do0_q    <= '0;
            do1_q    <= '0;
            do2_q    <= '0;
            col_q    <= '0;
            ld_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (!enb) begin
            // stall: pulses are dropped rather than replayed when enb returns
            ld_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ld_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                if (last_col) begin
                    col <= '0;
                    if (!last_row) row <= row + ONE;
                end else begin
                    col <= col + ONE;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_q  <= cfg_width;
                        height_q <= cfg_height;
                        col      <= '0;
                        row      <= '0;
                        if (cfg_ok) begin
`ifdef AL_ACCEL_LB_PAD_EN
                            state <= S_STREAM;
`else
                            state <= S_FILL;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (accept && last_col && (row == ONE)) state <= S_STREAM;
                end
                S_STREAM: begin
                    if (accept) begin
                        do0_q <= tap0;
                        do1_q <= tap1;
                        do2_q <= in_data;
                        col_q <= col;
                        ld_q  <= 1'b1;
                        if (last_col && last_row) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign lb_do_0    = do0_q;
    assign lb_do_1    = do1_q;
    assign lb_do_2    = do2_q;
    assign lb_col     = col_q;
    assign lb_ld_wrn  = ld_q && enb;
    assign frame_done = done_q && enb;
    assign cfg_err    = err_q && enb;
    assign busy       = (state == S_FILL) || (state == S_STREAM);

endmodule

// File: tb/tb_al_accel_linebuf.sv
// Directed bench for al_accel_linebuf: per-cycle vector table plus a
// hand-written max-width frame with toggling valid.
// Build with AL_ACCEL_LB_PAD_EN to exercise the zero-padded variant.
module tb_al_accel_linebuf;

    localparam int IMG_W    = 28;
    localparam int COL_BITS = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                enb;
    logic                start;
    logic [COL_BITS-1:0] cfg_width;
    logic [COL_BITS-1:0] cfg_height;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic [7:0]          lb_do_0;
    logic [7:0]          lb_do_1;
    logic [7:0]          lb_do_2;
    logic                lb_ld_wrn;
    logic [COL_BITS-1:0] lb_col;
    logic                busy;
    logic                frame_done;
    logic                cfg_err;

    al_accel_linebuf #(.IMG_W(IMG_W), .COL_BITS(COL_BITS)) dut (
        .clk(clk), .reset(reset), .enb(enb), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lb_do_0(lb_do_0), .lb_do_1(lb_do_1), .lb_do_2(lb_do_2),
        .lb_ld_wrn(lb_ld_wrn), .lb_col(lb_col), .busy(busy),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                  rst, en, st, vl;
        logic [7:0]          d;
        logic [COL_BITS-1:0] w, h;
        bit                  eld;
        logic [COL_BITS-1:0] ecol;
        logic [7:0]          e0, e1, e2;
        bit                  ebusy, edone, eerr;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cur   = -1;

    // held output model: values persist between strobes, cleared by reset
    logic [COL_BITS-1:0] m_col = '0;
    logic [7:0]          m0 = '0, m1 = '0, m2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %0d expected %0d", name, cur, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input bit rst, en, st, vl, input logic [7:0] d,
                                input logic [COL_BITS-1:0] w, h,
                                input bit eld, input logic [COL_BITS-1:0] ecol,
                                input logic [7:0] e0, e1, e2,
                                input bit ebusy, edone, eerr);
        vec_t v;
        if (rst) begin
            m_col = '0; m0 = '0; m1 = '0; m2 = '0;
        end else if (eld) begin
            m_col = ecol; m0 = e0; m1 = e1; m2 = e2;
        end
        v.rst = rst; v.en = en; v.st = st; v.vl = vl; v.d = d; v.w = w; v.h = h;
        v.eld = eld; v.ecol = m_col; v.e0 = m0; v.e1 = m1; v.e2 = m2;
        v.ebusy = ebusy; v.edone = edone; v.eerr = eerr;
        vq.push_back(v);
    endfunction

    function automatic void idle(input bit ebusy, edone, eerr);
        add(0, 1, 0, 0, 8'd0, 10'd4, 10'd3, 0, '0, 0, 0, 0, ebusy, edone, eerr);
    endfunction

`ifndef AL_ACCEL_LB_PAD_EN
    // 4x3 frame, pixels base..base+11; optional 3-cycle stall after pixel stall_after
    function automatic void frame4x3(input int base, input int stall_after);
        int x;
        add(0, 1, 1, 0, 8'd0, 10'd4, 10'd3, 0, '0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k < 9) begin
                add(0, 1, 0, 1, 8'(base + k - 1), 10'd4, 10'd3, 0, '0, 0, 0, 0, 1, 0, 0);
            end else begin
                x = k - 9;
                add(0, 1, 0, 1, 8'(base + k - 1), 10'd4, 10'd3, 1, COL_BITS'(x),
                    8'(base + x), 8'(base + x + 4), 8'(base + x + 8), (k < 12), 0, 0);
            end
            if (k == stall_after)
                for (int s = 0; s < 3; s++)
                    add(0, 0, 0, 1, 8'hEE, 10'd4, 10'd3, 0, '0, 0, 0, 0, 1, 0, 0);
        end
        idle(0, 1, 0);
        idle(0, 0, 0);
    endfunction
`endif

    initial begin
        vec_t v;
        int   p, x, y, seen;
        bit   acc, restarted;

        reset = 1; enb = 1; start = 0; cfg_width = '0; cfg_height = '0;
        in_valid = 0; in_data = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ld", lb_ld_wrn, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_col", lb_col, 0);
        chk("rst_do", {lb_do_0, lb_do_1, lb_do_2}, 0);
        reset = 0;

`ifndef AL_ACCEL_LB_PAD_EN
        frame4x3(1, 0);
        frame4x3(1, 10);
        add(0, 1, 1, 0, 8'd0, 10'd0, 10'd3, 0, '0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0);
        add(0, 1, 1, 0, 8'd0, 10'(IMG_W + 1), 10'd3, 0, '0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0);
        add(0, 1, 1, 0, 8'd0, 10'd4, 10'd2, 0, '0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0);
        add(0, 1, 1, 0, 8'd0, 10'd4, 10'd3, 0, '0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++)
            add(0, 1, 0, 1, 8'(k), 10'd4, 10'd3, 0, '0, 0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 8'd0, 10'd4, 10'd3, 0, '0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0);
        idle(0, 0, 0);
        frame4x3(101, 0);
`else
        add(0, 1, 1, 0, 8'd0, 10'd0, 10'd3, 0, '0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0);
        add(0, 1, 1, 0, 8'd0, 10'(IMG_W + 1), 10'd3, 0, '0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0);
        add(0, 1, 1, 0, 8'd0, 10'd4, 10'd0, 0, '0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0);
        add(0, 1, 1, 0, 8'd0, 10'd2, 10'd2, 0, '0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 0, 1, 8'd1, 10'd2, 10'd2, 1, 10'd0, 8'd0, 8'd0, 8'd1, 1, 0, 0);
        add(0, 1, 0, 1, 8'd2, 10'd2, 10'd2, 1, 10'd1, 8'd0, 8'd0, 8'd2, 1, 0, 0);
        add(0, 1, 0, 1, 8'd3, 10'd2, 10'd2, 1, 10'd0, 8'd0, 8'd1, 8'd3, 1, 0, 0);
        add(0, 1, 0, 1, 8'd4, 10'd2, 10'd2, 1, 10'd1, 8'd0, 8'd2, 8'd4, 0, 0, 0);
        idle(0, 1, 0);
        idle(0, 0, 0);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            cur = i;
            reset = v.rst; enb = v.en; start = v.st; in_valid = v.vl; in_data = v.d;
            cfg_width = v.w; cfg_height = v.h;
            tick();
            chk("ld", lb_ld_wrn, v.eld);
            chk("busy", busy, v.ebusy);
            chk("done", frame_done, v.edone);
            chk("err", cfg_err, v.eerr);
            chk("col", lb_col, v.ecol);
            chk("do", {lb_do_0, lb_do_1, lb_do_2}, {v.e0, v.e1, v.e2});
            if (!v.en) chk("stall_ready", in_ready, 0);
        end
        reset = 0; enb = 1; start = 0; in_valid = 0;

`ifndef AL_ACCEL_LB_PAD_EN
        // max-width 4-row frame, valid on alternate cycles, stray start in STREAM
        cur = -1;
        start = 1; cfg_width = 10'(IMG_W); cfg_height = 10'd4;
        tick();
        start = 0;
        chk("t5_busy", busy, 1);
        p = 0; seen = 0; restarted = 0;
        for (int cyc = 0; cyc < 300 && p < 4 * IMG_W; cyc++) begin
            in_valid = (cyc % 2 == 0);
            in_data  = 8'(p + 1);
            if (!in_valid && p == 2 * IMG_W + 5 && !restarted) begin
                start = 1; cfg_width = 10'd5; cfg_height = 10'd3; restarted = 1;
            end
            acc = in_valid;
            tick();
            start = 0;
            if (lb_ld_wrn) seen++;
            if (acc) begin
                y = p / IMG_W;
                x = p % IMG_W;
                if (y >= 2) begin
                    chk("t5_ld", lb_ld_wrn, 1);
                    chk("t5_col", lb_col, x);
                    chk("t5_do0", lb_do_0, (y - 2) * IMG_W + x + 1);
                    chk("t5_do1", lb_do_1, (y - 1) * IMG_W + x + 1);
                    chk("t5_do2", lb_do_2, y * IMG_W + x + 1);
                end else begin
                    chk("t5_fill_ld", lb_ld_wrn, 0);
                end
                p++;
            end else begin
                chk("t5_gap_ld", lb_ld_wrn, 0);
            end
        end
        chk("t5_pixels", p, 4 * IMG_W);
        in_valid = 0;
        tick();
        chk("t5_done", frame_done, 1);
        chk("t5_strobes", seen, 2 * IMG_W);
        tick();
        chk("t5_idle_busy", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
